// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM stage of the 5-stage pipeline. Takes the EX/MEM slot, resolves
//   conditional branches, runs a req/ack transaction to data memory with
//   big-endian byte/half/word lanes, stalls the upstream pipeline while memory
//   is busy and produces the registered MEM/WB slot.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   inValid .. rd     : EX/MEM slot (valid, ALU result/address, store data,
//                       zero flag, branch controls, memory controls, rd)
//   dmemReq .. dmemAck: data-memory handshake (request, write, word address,
//                       byte enables, write data, read data, ack pulse)
//   stall             : freezes PC, IF/ID, ID/EX and EX/MEM
//   pcRedirect/Target : taken-branch redirect
//   wbValid .. wbRegWr: registered MEM/WB slot
//   excMisalign/BusErr: registered one-cycle exception pulses, aligned with
//                       the MEM/WB update of the dropped instruction
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    input  logic [31:0] aluRes,
    input  logic [31:0] storeData,
    input  logic        isZero,
    input  logic        branch,
    input  logic        branchNe,
    input  logic [31:0] branchTgt,
    input  logic        memRd,
    input  logic        memWr,
    input  logic [1:0]  memSize,
    input  logic        memSext,
    input  logic        regWr,
    input  logic [4:0]  rd,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [3:0]  dmemBe,
    output logic [31:0] dmemWdata,
    input  logic [31:0] dmemRdata,
    input  logic        dmemAck,
    output logic        stall,
    output logic        pcRedirect,
    output logic [31:0] pcTarget,
    output logic        wbValid,
    output logic [31:0] wbData,
    output logic [4:0]  wbRd,
    output logic        wbRegWr,
    output logic        excMisalign,
    output logic        excBusErr
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Lane helpers (big-endian: lane 0 is bits [31:24])
    // -------------------------------------------------------------------------
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] ofs);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~ofs[0];
            default: ok = (ofs == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            2'b00: begin
                case (ofs)
                    2'b00:   be = 4'b1000;
                    2'b01:   be = 4'b0100;
                    2'b10:   be = 4'b0010;
                    default: be = 4'b0001;
                endcase
            end
            2'b01:   be = ofs[1] ? 4'b0011 : 4'b1100;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{data[7:0]}};
            2'b01:   w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_format(input logic [1:0] size, input logic sext,
                                                input logic [1:0] ofs, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        case (size)
            2'b00: begin
                case (ofs)
                    2'b00:   b = data[31:24];
                    2'b01:   b = data[23:16];
                    2'b10:   b = data[15:8];
                    default: b = data[7:0];
                endcase
                r = {{24{sext & b[7]}}, b};
            end
            2'b01: begin
                h = ofs[1] ? data[15:0] : data[31:16];
                r = {{16{sext & h[15]}}, h};
            end
            default: r = data;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State, wait counter and latched request
    // -------------------------------------------------------------------------
    state_t      state_r, state_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;

    logic        req_we_r;
    logic [31:0] req_addr_r;
    logic [3:0]  req_be_r;
    logic [31:0] req_wdata_r;
    logic [1:0]  req_ofs_r;
    logic [1:0]  req_size_r;
    logic        req_sext_r;
    logic        req_load_r;
    logic        req_regwr_r;
    logic [4:0]  req_rd_r;

    logic        mem_op_s;
    logic        aligned_s;
    logic        issue_s;
    logic        complete_s;
    logic        abort_s;
    logic        misalign_s;
    logic        req_s;
    logic        stall_s;

    // Current transaction view: live inputs in IDLE, latched copy in BUSY
    logic        cur_we_s;
    logic [31:0] cur_addr_s;
    logic [3:0]  cur_be_s;
    logic [31:0] cur_wdata_s;
    logic [1:0]  cur_ofs_s;
    logic [1:0]  cur_size_s;
    logic        cur_sext_s;
    logic        cur_load_s;
    logic        cur_regwr_s;
    logic [4:0]  cur_rd_s;

    // A load+store combination is treated as a load only
    assign mem_op_s  = inValid & (memRd | memWr);
    assign aligned_s = is_aligned(memSize, aluRes[1:0]);

    // Select live or latched transaction fields
    always_comb begin
        if (state_r == ST_BUSY) begin
            cur_we_s    = req_we_r;
            cur_addr_s  = req_addr_r;
            cur_be_s    = req_be_r;
            cur_wdata_s = req_wdata_r;
            cur_ofs_s   = req_ofs_r;
            cur_size_s  = req_size_r;
            cur_sext_s  = req_sext_r;
            cur_load_s  = req_load_r;
            cur_regwr_s = req_regwr_r;
            cur_rd_s    = req_rd_r;
        end else begin
            cur_we_s    = memWr & ~memRd;
            cur_addr_s  = {aluRes[31:2], 2'b00};
            cur_be_s    = byte_enables(memSize, aluRes[1:0]);
            cur_wdata_s = store_lanes(memSize, storeData);
            cur_ofs_s   = aluRes[1:0];
            cur_size_s  = memSize;
            cur_sext_s  = memSext;
            cur_load_s  = memRd;
            cur_regwr_s = regWr;
            cur_rd_s    = rd;
        end
    end

    // Next-state logic and handshake control
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        issue_s    = 1'b0;
        complete_s = 1'b0;
        abort_s    = 1'b0;
        misalign_s = 1'b0;
        req_s      = 1'b0;
        stall_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // rst_n gating keeps the request low while reset is asserted
                if (rst_n && mem_op_s && aligned_s) begin
                    issue_s = 1'b1;
                    req_s   = 1'b1;
                    if (dmemAck) begin
                        complete_s = 1'b1;
                    end else begin
                        stall_s    = 1'b1;
                        state_s    = ST_BUSY;
                        wait_cnt_s = 8'd0;
                    end
                end else if (rst_n && mem_op_s) begin
                    misalign_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Timeout wins: the request is already withdrawn this cycle
                if (wait_cnt_r == WAIT_LIMIT) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (dmemAck) begin
                    req_s      = 1'b1;
                    complete_s = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    req_s      = 1'b1;
                    stall_s    = 1'b1;
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Capture the request when it has to wait for an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_r    <= 1'b0;
            req_addr_r  <= 32'h0000_0000;
            req_be_r    <= 4'b0000;
            req_wdata_r <= 32'h0000_0000;
            req_ofs_r   <= 2'b00;
            req_size_r  <= 2'b00;
            req_sext_r  <= 1'b0;
            req_load_r  <= 1'b0;
            req_regwr_r <= 1'b0;
            req_rd_r    <= 5'd0;
        end else if (issue_s && !dmemAck) begin
            req_we_r    <= cur_we_s;
            req_addr_r  <= cur_addr_s;
            req_be_r    <= cur_be_s;
            req_wdata_r <= cur_wdata_s;
            req_ofs_r   <= cur_ofs_s;
            req_size_r  <= cur_size_s;
            req_sext_r  <= cur_sext_s;
            req_load_r  <= cur_load_s;
            req_regwr_r <= cur_regwr_s;
            req_rd_r    <= cur_rd_s;
        end else begin
            req_we_r    <= req_we_r;
        end
    end

    // Memory bus drive: all fields forced to zero while no request is open
    always_comb begin
        dmemReq = req_s;
        stall   = stall_s;
        if (req_s) begin
            dmemWe    = cur_we_s;
            dmemAddr  = cur_addr_s;
            dmemBe    = cur_be_s;
            dmemWdata = cur_wdata_s;
        end else begin
            dmemWe    = 1'b0;
            dmemAddr  = 32'h0000_0000;
            dmemBe    = 4'b0000;
            dmemWdata = 32'h0000_0000;
        end
    end

    // Branch resolution; branches never access memory so they never stall
    always_comb begin
        pcRedirect = rst_n & (state_r == ST_IDLE) & ~mem_op_s & inValid & branch
                   & (isZero ^ branchNe);
        if (pcRedirect) begin
            pcTarget = branchTgt;
        end else begin
            pcTarget = 32'h0000_0000;
        end
    end

    // MEM/WB slot and exception pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbValid     <= 1'b0;
            wbData      <= 32'h0000_0000;
            wbRd        <= 5'd0;
            wbRegWr     <= 1'b0;
            excMisalign <= 1'b0;
            excBusErr   <= 1'b0;
        end else begin
            excMisalign <= misalign_s;
            excBusErr   <= abort_s;
            if (complete_s) begin
                wbValid <= 1'b1;
                wbRd    <= cur_rd_s;
                wbRegWr <= cur_regwr_s & cur_load_s;
                wbData  <= cur_load_s ? load_format(cur_size_s, cur_sext_s, cur_ofs_s, dmemRdata)
                                      : 32'h0000_0000;
            end else if (state_r == ST_IDLE && inValid && !mem_op_s) begin
                wbValid <= 1'b1;
                wbRd    <= rd;
                wbRegWr <= regWr & ~branch;
                wbData  <= aluRes;
            end else begin
                // stall, bubble, misaligned drop or bus-error drop
                wbValid <= 1'b0;
                wbRegWr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int TB_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic [31:0] aluRes;
    logic [31:0] storeData;
    logic        isZero;
    logic        branch;
    logic        branchNe;
    logic [31:0] branchTgt;
    logic        memRd;
    logic        memWr;
    logic [1:0]  memSize;
    logic        memSext;
    logic        regWr;
    logic [4:0]  rd;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [3:0]  dmemBe;
    logic [31:0] dmemWdata;
    logic [31:0] dmemRdata;
    logic        dmemAck;
    logic        stall;
    logic        pcRedirect;
    logic [31:0] pcTarget;
    logic        wbValid;
    logic [31:0] wbData;
    logic [4:0]  wbRd;
    logic        wbRegWr;
    logic        excMisalign;
    logic        excBusErr;

    int compared   = 0;
    int mismatched = 0;

    mem_stage #(.WAIT_MAX(TB_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .aluRes(aluRes),
        .storeData(storeData), .isZero(isZero), .branch(branch), .branchNe(branchNe),
        .branchTgt(branchTgt), .memRd(memRd), .memWr(memWr), .memSize(memSize),
        .memSext(memSext), .regWr(regWr), .rd(rd), .dmemReq(dmemReq), .dmemWe(dmemWe),
        .dmemAddr(dmemAddr), .dmemBe(dmemBe), .dmemWdata(dmemWdata),
        .dmemRdata(dmemRdata), .dmemAck(dmemAck), .stall(stall),
        .pcRedirect(pcRedirect), .pcTarget(pcTarget), .wbValid(wbValid),
        .wbData(wbData), .wbRd(wbRd), .wbRegWr(wbRegWr),
        .excMisalign(excMisalign), .excBusErr(excBusErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules written as plain arithmetic on the byte offset
    function automatic logic ref_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] one_byte;
        logic [3:0] two_byte;
        one_byte = 4'b1000;
        two_byte = 4'b1100;
        if (sz == 2'd0) return one_byte >> (a % 4);
        if (sz == 2'd1) return two_byte >> (a % 4);
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] d);
        int unsigned w;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 2'd0) begin
            w  = 8;
            sh = 8 * (3 - (a % 4));
        end else if (sz == 2'd1) begin
            w  = 16;
            sh = 16 * (1 - (a % 4) / 2);
        end else begin
            return d;
        end
        mask = (32'h1 << w) - 32'h1;
        v    = (d >> sh) & mask;
        if (sx && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic bubble();
        inValid = 1'b0; memRd = 1'b0; memWr = 1'b0; branch = 1'b0; regWr = 1'b0;
        dmemAck = 1'b0;
    endtask

    // One instruction through MEM: ack_dly is the cycle index of the ack
    // (0 = same cycle as the request); ack_dly > TB_WAIT means no ack.
    task automatic run_op(input logic v, input logic ld, input logic st,
                          input logic [1:0] sz, input logic sx, input logic [31:0] a,
                          input logic [31:0] sd, input logic rw, input logic [4:0] r,
                          input logic br, input logic bne, input logic z,
                          input logic [31:0] tgt, input int ack_dly, input logic [31:0] rdat);
        logic is_mem;
        logic done;
        logic redirect;
        inValid = v; memRd = ld; memWr = st; memSize = sz; memSext = sx;
        aluRes = a; storeData = sd; regWr = rw; rd = r;
        branch = br; branchNe = bne; isZero = z; branchTgt = tgt;
        dmemAck = 1'b0;
        is_mem = v && (ld || st);
        if (is_mem && ref_aligned(sz, a)) begin
            done = 1'b0;
            for (int c = 0; c <= TB_WAIT && !done; c++) begin
                dmemAck   = (c == ack_dly);
                dmemRdata = (c == ack_dly) ? rdat : $urandom;
                #1;
                chk("req", dmemReq, 1);
                chk("addr", dmemAddr, a & 32'hFFFF_FFFC);
                chk("we", dmemWe, st && !ld);
                chk("be", dmemBe, ref_be(sz, a));
                chk("wdata", dmemWdata, ref_wdata(sz, sd));
                chk("stall", stall, c != ack_dly);
                chk("redirect_mem", pcRedirect, 0);
                @(posedge clk); #1;
                if (c == ack_dly) begin
                    done = 1'b1;
                end else begin
                    chk("wb_stall_bubble", wbValid, 0);
                end
            end
            dmemAck = 1'b0;
            if (done) begin
                chk("wb_valid", wbValid, 1);
                chk("wb_rd", wbRd, r);
                chk("wb_regwr", wbRegWr, rw && ld);
                chk("wb_data", wbData, ld ? ref_load(sz, sx, a, rdat) : 32'h0);
                chk("buserr_idle", excBusErr, 0);
            end else begin
                #1;
                chk("abort_req", dmemReq, 0);
                chk("abort_stall", stall, 0);
                @(posedge clk); #1;
                chk("buserr", excBusErr, 1);
                chk("abort_wbvalid", wbValid, 0);
                chk("abort_wbregwr", wbRegWr, 0);
            end
            chk("misalign_mem", excMisalign, 0);
        end else begin
            redirect = v && !is_mem && br && (z ^ bne);
            #1;
            chk("noreq", dmemReq, 0);
            chk("nostall", stall, 0);
            chk("redirect", pcRedirect, redirect);
            if (redirect) chk("target", pcTarget, tgt);
            @(posedge clk); #1;
            chk("misalign", excMisalign, is_mem);
            chk("buserr_none", excBusErr, 0);
            chk("wb_valid_nm", wbValid, v && !is_mem);
            chk("wb_regwr_nm", wbRegWr, v && !is_mem && rw && !br);
            if (v && !is_mem) begin
                chk("wb_data_alu", wbData, a);
                chk("wb_rd_nm", wbRd, r);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, dmemReq, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_wbvalid"}, wbValid, 0);
        chk({tag, "_wbdata"}, wbData, 0);
        chk({tag, "_wbrd"}, wbRd, 0);
        chk({tag, "_wbregwr"}, wbRegWr, 0);
        chk({tag, "_redirect"}, pcRedirect, 0);
        chk({tag, "_excs"}, {excMisalign, excBusErr}, 0);
        chk({tag, "_addr"}, dmemAddr, 0);
    endtask

    initial begin
        int kind;
        logic [1:0] sz;
        logic [31:0] a;

        rst_n = 1'b0;
        aluRes = 32'h0; storeData = 32'h0; isZero = 1'b0; branchNe = 1'b0;
        branchTgt = 32'h0; memSize = 2'd0; memSext = 1'b0; rd = 5'd0;
        dmemRdata = 32'h0;
        bubble();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 1, 5'd3, 0, 0, 0, 32'h0, 3, 32'hDEAD_BEEF);
        run_op(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 5'd4, 0, 0, 0, 32'h0, 0, 32'h0000_00F0);
        run_op(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 5'd5, 0, 0, 0, 32'h0, 0, 32'h0000_00F0);
        run_op(1, 0, 1, 2'd1, 0, 32'h102, 32'h1234_ABCD, 1, 5'd6, 0, 0, 0, 32'h0, 1, 32'h0);
        run_op(1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 1, 5'd7, 0, 0, 0, 32'h0, 0, 32'h0);
        run_op(1, 0, 0, 2'd0, 0, 32'h55, 32'h0, 0, 5'd0, 1, 0, 1, 32'h0000_4000, 0, 32'h0);
        run_op(1, 0, 0, 2'd0, 0, 32'h55, 32'h0, 0, 5'd0, 1, 1, 1, 32'h0000_4000, 0, 32'h0);
        run_op(1, 0, 0, 2'd0, 0, 32'h1357_9BDF, 32'h0, 1, 5'd9, 0, 0, 0, 32'h0, 0, 32'h0);
        run_op(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 5'd1, 0, 0, 0, 32'h0, 0, 32'h0);
        // Bus error with no ack, then a late ack with nothing pending
        run_op(1, 1, 0, 2'd2, 0, 32'h200, 32'h0, 1, 5'd8, 0, 0, 0, 32'h0, TB_WAIT + 1, 32'h0);
        bubble();
        dmemAck = 1'b1;
        #1;
        chk("late_ack_req", dmemReq, 0);
        @(posedge clk); #1;
        chk("late_ack_wb", wbValid, 0);
        dmemAck = 1'b0;

        // Randomized mix against the reference rules
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 5);
            sz   = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
                else if (sz != 2'd0) a = a & 32'hFFFF_FFFC;
            end
            case (kind)
                0: run_op(1, 1, 0, sz, 1'($urandom), a, $urandom, 1'($urandom), 5'($urandom),
                          0, 0, 0, 32'h0, $urandom_range(0, TB_WAIT + 1), $urandom);
                1: run_op(1, 0, 1, sz, 1'($urandom), a, $urandom, 1'($urandom), 5'($urandom),
                          0, 0, 0, 32'h0, $urandom_range(0, TB_WAIT + 1), $urandom);
                2: run_op(1, 1, 1, sz, 1'($urandom), a, $urandom, 1'($urandom), 5'($urandom),
                          0, 0, 0, 32'h0, $urandom_range(0, TB_WAIT), $urandom);
                3: run_op(1, 0, 0, sz, 0, a, $urandom, 1'($urandom), 5'($urandom),
                          0, 0, 0, 32'h0, 0, 32'h0);
                4: run_op(1, 0, 0, sz, 0, a, 32'h0, 1'($urandom), 5'($urandom),
                          1, 1'($urandom), 1'($urandom), $urandom, 0, 32'h0);
                default: run_op(0, 1'($urandom), 1'($urandom), sz, 0, a, 32'h0, 1'($urandom),
                                5'($urandom), 0, 0, 0, 32'h0, 0, 32'h0);
            endcase
        end

        // Reset in the middle of a BUSY transaction
        inValid = 1'b1; memRd = 1'b1; memWr = 1'b0; memSize = 2'd2; aluRes = 32'h300;
        regWr = 1'b1; rd = 5'd10; branch = 1'b0; dmemAck = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("busy_req", dmemReq, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        bubble();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_reset_req", dmemReq, 0);
        chk("after_reset_wb", wbValid, 0);
        run_op(1, 1, 0, 2'd1, 1, 32'h402, 32'h0, 1, 5'd11, 0, 0, 0, 32'h0, 2, 32'h1234_8765);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
